vm2002_change_dispenser: RTL and testbench



---
 rtl/vm2002_common_pkg.sv | 39 +++
 rtl/vm2002_coin_tube.sv | 37 +++
 rtl/vm2002_change_dispenser.sv | 172 +++++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vm2002_common_pkg.sv
// Shared vm2002 types: coin encoding, change-dispenser state/status, coin values.
package vm2002_common_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coins_t;

  typedef enum logic [1:0] {
    CD_IDLE     = 2'd0,
    CD_SELECT   = 2'd1,
    CD_DISPENSE = 2'd2,
    CD_DONE     = 2'd3
  } cd_state_t;

  typedef enum logic [1:0] {
    CS_OK    = 2'd0,
    CS_SHORT = 2'd1,
    CS_FAULT = 2'd2,
    CS_ABORT = 2'd3
  } change_status_t;

  localparam int COIN_VAL_W = 5;
  localparam logic [COIN_VAL_W-1:0] NICKEL_VAL  = 5'd5;
  localparam logic [COIN_VAL_W-1:0] DIME_VAL    = 5'd10;
  localparam logic [COIN_VAL_W-1:0] QUARTER_VAL = 5'd25;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input coins_t c);
    case (c)
      COIN_NICKEL:  coin_value = NICKEL_VAL;
      COIN_DIME:    coin_value = DIME_VAL;
      COIN_QUARTER: coin_value = QUARTER_VAL;
      default:      coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/vm2002_coin_tube.sv
// One coin tube: saturating load-add and a decrement that never wraps below 0.
module vm2002_coin_tube #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_count,
  input  logic             dec_en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  // Carry out of the widened sum is the saturation indicator.
  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, load_count};
    sat   = sum[CNT_W];
    cnt_d = cnt_q;
    if (load_en)
      cnt_d = sat ? '1 : sum[CNT_W-1:0];
    else if (dec_en && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Greedy coin-return sequencer with per-denomination tubes.
// Optional VM2002_EXACT_CHANGE_EN adds a registered exact_change flag.
module vm2002_change_dispenser
  import vm2002_common_pkg::*;
#(
  parameter int BAL_W       = 16,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             srst,
  input  logic             req_valid,
  input  logic [BAL_W-1:0] req_amount,
  output logic             req_ready,
  output logic             done,
  output logic [1:0]       done_status,
  output logic [BAL_W-1:0] remaining,
  output coins_t           coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  input  logic             load_valid,
  input  coins_t           load_coin,
  input  logic [CNT_W-1:0] load_count,
  output logic             load_err,
`ifdef VM2002_EXACT_CHANGE_EN
  output logic             exact_change,
`endif
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] quarter_cnt
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  cd_state_t        state_q, state_d;
  change_status_t   status_q, status_d;
  coins_t           coin_q, coin_d, pick;
  logic [BAL_W-1:0] rem_q, rem_d, coin_val;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             load_err_q, load_err_d;
  logic             load_ok;

  // Tube index 0/1/2 holds nickels/dimes/quarters, i.e. coin code i+1.
  logic [2:0][CNT_W-1:0] cnt;
  logic [2:0]            load_en, dec_en, sat;

  assign load_ok = load_valid && (state_q == CD_IDLE) && (load_coin != COIN_NONE);

  for (genvar i = 0; i < 3; i++) begin : g_tube
    assign load_en[i] = load_ok && (load_coin == coins_t'(2'(i + 1)));
    assign dec_en[i]  = (state_q == CD_DISPENSE) && coin_ack && (coin_q == coins_t'(2'(i + 1)));
    vm2002_coin_tube #(.CNT_W(CNT_W)) u_tube (
      .clk        (clk),
      .hrst_n     (hrst_n),
      .load_en    (load_en[i]),
      .load_count (load_count),
      .dec_en     (dec_en[i]),
      .cnt        (cnt[i]),
      .sat        (sat[i])
    );
  end

  assign load_err_d = load_valid && (!load_ok || |(load_en & sat));

  // Greedy pick: largest coin that fits the balance and is in stock.
  always_comb begin
    pick = COIN_NONE;
    if      (rem_q >= BAL_W'(QUARTER_VAL) && cnt[2] != '0) pick = COIN_QUARTER;
    else if (rem_q >= BAL_W'(DIME_VAL)    && cnt[1] != '0) pick = COIN_DIME;
    else if (rem_q >= BAL_W'(NICKEL_VAL)  && cnt[0] != '0) pick = COIN_NICKEL;
  end

  assign coin_val = BAL_W'(coin_value(coin_q));

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q    <= CD_IDLE;
      status_q   <= CS_OK;
      coin_q     <= COIN_NONE;
      rem_q      <= '0;
      tmo_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      coin_q     <= coin_d;
      rem_q      <= rem_d;
      tmo_q      <= tmo_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    coin_d   = coin_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    case (state_q)
      CD_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          state_d = CD_SELECT;
        end
      end
      CD_SELECT: begin
        tmo_d = '0;
        if (srst) begin
          state_d  = CD_DONE;
          status_d = CS_ABORT;
        end else if (rem_q == '0) begin
          state_d  = CD_DONE;
          status_d = CS_OK;
        end else if (pick != COIN_NONE) begin
          coin_d  = pick;
          state_d = CD_DISPENSE;
        end else begin
          state_d  = CD_DONE;
          status_d = CS_SHORT;
        end
      end
      CD_DISPENSE: begin
        // An ack coinciding with srst still pays the coin before aborting.
        if (coin_ack) begin
          rem_d   = (rem_q > coin_val) ? rem_q - coin_val : '0;
          state_d = CD_SELECT;
        end else if (!srst) begin
          if (tmo_q == TMO_LAST) begin
            state_d  = CD_DONE;
            status_d = CS_FAULT;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        if (srst) begin
          state_d  = CD_DONE;
          status_d = CS_ABORT;
        end
      end
      default: state_d = CD_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == CD_IDLE);
    done        = (state_q == CD_DONE);
    coin_valid  = (state_q == CD_DISPENSE);
    coin_out    = coin_valid ? coin_q : COIN_NONE;
    done_status = status_q;
    remaining   = rem_q;
    load_err    = load_err_q;
    nickel_cnt  = cnt[0];
    dime_cnt    = cnt[1];
    quarter_cnt = cnt[2];
  end

`ifdef VM2002_EXACT_CHANGE_EN
  logic exact_q, exact_d;

  assign exact_d = (cnt[0] == '0) || ((cnt[1] == '0) && (cnt[0] < CNT_W'(2)));

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) exact_q <= 1'b1;
    else         exact_q <= exact_d;
  end

  assign exact_change = exact_q;
`endif

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Randomized bench for vm2002_change_dispenser against a greedy-payout reference model.
module tb_vm2002_change_dispenser;
  import vm2002_common_pkg::*;

  localparam int BAL_W  = 16;
  localparam int CNT_W  = 8;
  localparam int ACK_TO = 64;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             hrst_n = 1'b0;
  logic             srst = 1'b0;
  logic             req_valid = 1'b0;
  logic [BAL_W-1:0] req_amount = '0;
  logic             req_ready, done, coin_valid, load_err;
  logic [1:0]       done_status;
  logic [BAL_W-1:0] remaining;
  coins_t           coin_out;
  logic             coin_ack = 1'b0;
  logic             load_valid = 1'b0;
  coins_t           load_coin = COIN_NONE;
  logic [CNT_W-1:0] load_count = '0;
  logic [CNT_W-1:0] nickel_cnt, dime_cnt, quarter_cnt;
`ifdef VM2002_EXACT_CHANGE_EN
  logic             exact_change;
`endif

  always #5 clk = ~clk;

  vm2002_change_dispenser #(.BAL_W(BAL_W), .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .hrst_n(hrst_n), .srst(srst),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .done(done), .done_status(done_status), .remaining(remaining),
    .coin_out(coin_out), .coin_valid(coin_valid), .coin_ack(coin_ack),
    .load_valid(load_valid), .load_coin(load_coin), .load_count(load_count),
    .load_err(load_err),
`ifdef VM2002_EXACT_CHANGE_EN
    .exact_change(exact_change),
`endif
    .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .quarter_cnt(quarter_cnt)
  );

  int checks = 0;
  int fails  = 0;
  int mcnt[3];               // model tube contents: nickel, dime, quarter
  int vals[4] = '{0, 5, 10, 25};
  int last_status = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int greedy(input int rem);
    if (rem >= 25 && mcnt[2] > 0) return 3;
    if (rem >= 10 && mcnt[1] > 0) return 2;
    if (rem >= 5  && mcnt[0] > 0) return 1;
    return 0;
  endfunction

  task automatic check_counts();
    chk("nickel_cnt",  nickel_cnt,  mcnt[0]);
    chk("dime_cnt",    dime_cnt,    mcnt[1]);
    chk("quarter_cnt", quarter_cnt, mcnt[2]);
  endtask

  task automatic do_reset();
    hrst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    last_status = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_status", done_status, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_coin_out", coin_out, 0);
    chk("rst_load_err", load_err, 0);
`ifdef VM2002_EXACT_CHANGE_EN
    chk("rst_exact_change", exact_change, 1);
`endif
    check_counts();
    @(negedge clk);
    hrst_n = 1'b1;
    tick();
  endtask

  task automatic do_load(input int coin, input int n);
    bit err;
    int s;
    load_valid = 1'b1;
    load_coin  = coins_t'(coin);
    load_count = CNT_W'(n);
    tick();
    load_valid = 1'b0;
    err = (coin == 0);
    if (coin != 0) begin
      s = mcnt[coin-1] + n;
      if (s > MAXC) begin s = MAXC; err = 1; end
      mcnt[coin-1] = s;
    end
    chk("load_err", load_err, err);
    check_counts();
  endtask

  task automatic end_check(input int st, input int rem);
    chk("done", done, 1);
    chk("done_status", done_status, st);
    chk("remaining", remaining, rem);
    chk("coin_valid_off", coin_valid, 0);
    check_counts();
    last_status = st;
  endtask

  // mode 0: ack after dly cycles; 1: never ack coin k; 2: srst on coin k (with optional ack)
  task automatic run_req(input int amt, input int dly, input int mode, input int k,
                         input bit with_ack, input bit ld_disp);
    int rem, c, idx, n;
    bit fin;
    rem = amt; idx = 0; fin = 0;
    chk("req_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_amount = BAL_W'(amt);
    tick();
    req_valid = 1'b0;
    while (!fin) begin
      c = greedy(rem);
      chk("sel_coin_valid", coin_valid, 0);
      chk("sel_done", done, 0);
      if (c == 0) begin
        tick();
        end_check((rem == 0) ? 0 : 1, rem);
        fin = 1;
      end else begin
        tick();
        chk("coin_valid", coin_valid, 1);
        chk("coin_out", coin_out, c);
        if (mode == 1 && idx == k) begin
          n = 1;
          while (coin_valid && n < 200) begin
            tick();
            if (coin_valid) n++;
          end
          chk("ack_timeout_cycles", n, ACK_TO);
          end_check(2, rem);
          fin = 1;
        end else begin
          for (int i = 0; i < dly; i++) begin
            if (ld_disp && idx == 0 && i == 0) begin
              load_valid = 1'b1; load_coin = COIN_QUARTER; load_count = 8'd5;
            end
            tick();
            load_valid = 1'b0;
            if (ld_disp && idx == 0 && i == 0) chk("load_err_disp", load_err, 1);
            chk("coin_hold_valid", coin_valid, 1);
            chk("coin_hold_out", coin_out, c);
          end
          if (mode == 2 && idx == k) begin
            srst = 1'b1; coin_ack = with_ack;
            tick();
            srst = 1'b0; coin_ack = 1'b0;
            if (with_ack) begin mcnt[c-1]--; rem -= vals[c]; end
            end_check(3, rem);
            fin = 1;
          end else begin
            coin_ack = 1'b1;
            tick();
            coin_ack = 1'b0;
            mcnt[c-1]--;
            rem -= vals[c];
          end
        end
        idx++;
      end
    end
    tick();
    chk("idle_ready", req_ready, 1);
    chk("done_pulse", done, 0);
    chk("status_held", done_status, last_status);
  endtask

  initial begin
    int amt, r;
    do_reset();

    // stocked tubes, 40c -> quarter, dime, nickel
    for (int c = 1; c <= 3; c++) do_load(c, 10);
    run_req(40, 1, 0, 0, 0, 0);
    run_req(0, 0, 0, 0, 0, 0);

    // Q0/D1/N1, 30c -> dime, nickel, SHORT 15
    do_reset();
    do_load(2, 1);
    do_load(1, 1);
    run_req(30, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) do_load(c, MAXC);
    run_req(7, 0, 0, 0, 0, 0);

    run_req(25, 0, 1, 0, 0, 0);
    run_req(50, 1, 2, 1, 1, 0);
    run_req(50, 0, 2, 1, 0, 0);

    // srst while idle changes nothing
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("srst_idle_ready", req_ready, 1);
    chk("srst_idle_done", done, 0);

    do_reset();
    do_load(3, 250);
    do_load(3, 10);
    do_load(0, 5);
    do_load(2, 3);
    run_req(10, 2, 0, 0, 0, 1);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(1, 0) == 1) do_load($urandom_range(3, 0), $urandom_range(20, 0));
      amt = $urandom_range(130, 0);
      r   = $urandom_range(9, 0);
      run_req(amt, $urandom_range(2, 0), (r == 0) ? 1 : (r == 1) ? 2 : 0,
              $urandom_range(2, 0), $urandom_range(1, 0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
